// File: rtl/target_uart_monitor_if.sv
// Bundle for the glitch-target UART monitor: serial line, attempt controls and scored-frame results.
interface target_uart_monitor_if;
   logic        rx;
   logic        arm;
   logic        clr_cnt;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        frame_done;
   logic        frame_match;
   logic        frame_fault;
   logic        frame_err;
   logic [15:0] ok_cnt;
   logic [15:0] fault_cnt;
   logic [15:0] err_cnt;

   modport master (
      output rx, arm, clr_cnt,
      input  byte_valid, byte_data, frame_done, frame_match, frame_fault,
      input  frame_err, ok_cnt, fault_cnt, err_cnt
   );

   modport slave (
      input  rx, arm, clr_cnt,
      output byte_valid, byte_data, frame_done, frame_match, frame_fault,
      output frame_err, ok_cnt, fault_cnt, err_cnt
   );
endinterface

// File: rtl/target_uart_monitor.sv
// 8N1 receiver for the glitched AVR target's TX, frame assembler comparing against the known-good
// ciphertext, and saturating OK/FAULT/ERR attempt counters.
module target_uart_monitor #(
   parameter int unsigned                CLK_HZ       = 25125000,
   parameter int unsigned                BAUD         = 9600,
   parameter int unsigned                FRAME_BYTES  = 16,
   parameter logic [8*FRAME_BYTES-1:0]   EXPECTED     = 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
   parameter int unsigned                TIMEOUT_CLKS = CLK_HZ / 100
) (
   input logic                  clk,
   input logic                  rst_n,
   target_uart_monitor_if.slave bus
);

   localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
   localparam int unsigned IDX_W  = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
   localparam int unsigned IDLE_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;

   localparam logic [CNT_W-1:0]  BIT_FULL = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  BIT_HALF = CNT_W'(CLKS_PER_BIT / 2);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(FRAME_BYTES - 1);
   localparam logic [IDLE_W-1:0] TMO_LAST = IDLE_W'(TIMEOUT_CLKS - 1);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_START   = 3'd1;
   localparam logic [2:0] ST_DATA    = 3'd2;
   localparam logic [2:0] ST_STOP    = 3'd3;
   localparam logic [2:0] ST_RECOVER = 3'd4;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic logic [7:0] exp_byte(input logic [IDX_W-1:0] i);
      return EXPECTED[8*(FRAME_BYTES-1-int'(i)) +: 8];
   endfunction

   logic              rx_meta, rx_s;
   logic [2:0]        state;
   logic [CNT_W-1:0]  bit_cnt;
   logic [2:0]        bit_idx;
   logic [7:0]        shreg;
   logic              byte_valid;
   logic [7:0]        byte_data;

   logic [IDX_W-1:0]  idx;
   logic              flag;
   logic [IDLE_W-1:0] idle_cnt;
   logic              frame_done, frame_match, frame_fault, frame_err;
   logic [15:0]       ok_cnt, fault_cnt, err_cnt;

   logic              stop_fail, timeout_hit, flag_final, idle_run;

   // Receiver: synchronizer plus mid-bit sampling FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta    <= 1'b1;
         rx_s       <= 1'b1;
         state      <= ST_IDLE;
         bit_cnt    <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         byte_valid <= 1'b0;
         byte_data  <= '0;
      end else begin
         rx_meta    <= bus.rx;
         rx_s       <= rx_meta;
         byte_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (!rx_s) begin
                  state   <= ST_START;
                  bit_cnt <= BIT_HALF;
               end
            end
            ST_START: begin
               if (bit_cnt != '0) begin
                  bit_cnt <= bit_cnt - 1'b1;
               end else if (!rx_s) begin
                  state   <= ST_DATA;
                  bit_cnt <= BIT_FULL;
                  bit_idx <= '0;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_DATA: begin
               if (bit_cnt != '0) begin
                  bit_cnt <= bit_cnt - 1'b1;
               end else begin
                  shreg   <= {rx_s, shreg[7:1]};
                  bit_cnt <= BIT_FULL;
                  if (bit_idx == 3'd7) state <= ST_STOP;
                  else                 bit_idx <= bit_idx + 1'b1;
               end
            end
            ST_STOP: begin
               if (bit_cnt != '0) begin
                  bit_cnt <= bit_cnt - 1'b1;
               end else if (rx_s) begin
                  byte_valid <= 1'b1;
                  byte_data  <= shreg;
                  state      <= ST_IDLE;
               end else begin
                  state   <= ST_RECOVER;
                  bit_cnt <= BIT_FULL;
               end
            end
            ST_RECOVER: begin
               // A broken stop bit means the line may still be mid-character; wait for a full idle bit.
               if (!rx_s)                bit_cnt <= BIT_FULL;
               else if (bit_cnt == '0)   state   <= ST_IDLE;
               else                      bit_cnt <= bit_cnt - 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign stop_fail   = (state == ST_STOP) && (bit_cnt == '0) && !rx_s;
   assign idle_run    = (idx != '0) && (state == ST_IDLE);
   assign timeout_hit = idle_run && (idle_cnt == TMO_LAST);
   assign flag_final  = flag | (byte_data != exp_byte(idx));

   // Frame assembler: byte index, sticky mismatch flag and inter-byte timeout
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx         <= '0;
         flag        <= 1'b0;
         idle_cnt    <= '0;
         frame_done  <= 1'b0;
         frame_match <= 1'b0;
         frame_fault <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         frame_done  <= 1'b0;
         frame_match <= 1'b0;
         frame_fault <= 1'b0;
         frame_err   <= stop_fail | (timeout_hit & ~bus.arm);
         if (bus.arm || stop_fail || timeout_hit) begin
            idx      <= '0;
            flag     <= 1'b0;
            idle_cnt <= '0;
         end else if (byte_valid) begin
            idle_cnt <= '0;
            if (idx == IDX_LAST) begin
               frame_done  <= 1'b1;
               frame_match <= ~flag_final;
               frame_fault <= flag_final;
               idx         <= '0;
               flag        <= 1'b0;
            end else begin
               idx  <= idx + 1'b1;
               flag <= flag_final;
            end
         end else if (idle_run) begin
            idle_cnt <= idle_cnt + 1'b1;
         end else begin
            idle_cnt <= '0;
         end
      end
   end

   // Attempt counters; a clear request beats a same-cycle increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ok_cnt    <= '0;
         fault_cnt <= '0;
         err_cnt   <= '0;
      end else if (bus.clr_cnt) begin
         ok_cnt    <= '0;
         fault_cnt <= '0;
         err_cnt   <= '0;
      end else begin
         if (frame_done && frame_match) ok_cnt    <= sat_inc(ok_cnt);
         if (frame_done && frame_fault) fault_cnt <= sat_inc(fault_cnt);
         if (frame_err)                 err_cnt   <= sat_inc(err_cnt);
      end
   end

   assign bus.byte_valid  = byte_valid;
   assign bus.byte_data   = byte_data;
   assign bus.frame_done  = frame_done;
   assign bus.frame_match = frame_match;
   assign bus.frame_fault = frame_fault;
   assign bus.frame_err   = frame_err;
   assign bus.ok_cnt      = ok_cnt;
   assign bus.fault_cnt   = fault_cnt;
   assign bus.err_cnt     = err_cnt;

endmodule

// File: tb/tb_target_uart_monitor.sv
// Scoreboard bench for target_uart_monitor: directed attempt scenarios plus randomized frames.
module tb_target_uart_monitor;
   localparam int BIT_CLKS = 8;
   localparam int EV_BYTE = 0, EV_DONE = 1, EV_ERR = 2;

   typedef struct {
      int         kind;
      logic [7:0] data;
      bit         match;
   } ev_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   ev_t        exp_q[$];
   logic [7:0] exp_bytes [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
   int         m_idx = 0;
   bit         m_flag = 1'b0;
   int         m_ok = 0, m_fault = 0, m_err = 0;

   target_uart_monitor_if bus ();

   target_uart_monitor #(
      .CLK_HZ(76800), .BAUD(9600), .FRAME_BYTES(4),
      .EXPECTED(32'hDEADBEEF), .TIMEOUT_CLKS(200)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic spurious(input string name);
      checks++;
      failures++;
      $display("FAIL %s actual=pulse required=none", name);
   endtask

   // ---------------- reference model ----------------
   task automatic push_ev(input int kind, input logic [7:0] d, input bit m);
      ev_t e;
      e.kind = kind; e.data = d; e.match = m;
      exp_q.push_back(e);
   endtask

   task automatic model_byte(input logic [7:0] b, input bit armed);
      push_ev(EV_BYTE, b, 1'b0);
      if (armed) begin
         m_idx = 0; m_flag = 1'b0;
      end else begin
         if (b != exp_bytes[m_idx]) m_flag = 1'b1;
         if (m_idx == 3) begin
            push_ev(EV_DONE, 8'h00, !m_flag);
            if (m_flag) begin if (m_fault < 65535) m_fault++; end
            else        begin if (m_ok < 65535) m_ok++; end
            m_idx = 0; m_flag = 1'b0;
         end else begin
            m_idx++;
         end
      end
   endtask

   task automatic model_err();
      push_ev(EV_ERR, 8'h00, 1'b0);
      if (m_err < 65535) m_err++;
      m_idx = 0; m_flag = 1'b0;
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      bus.rx = 1'b0; idle(BIT_CLKS);
      for (int i = 0; i < 8; i++) begin
         bus.rx = b[i]; idle(BIT_CLKS);
      end
      bus.rx = stop_bit; idle(BIT_CLKS);
      bus.rx = 1'b1;
   endtask

   task automatic good_byte(input logic [7:0] b, input int gap);
      model_byte(b, 1'b0);
      send_byte(b, 1'b1);
      idle(gap);
   endtask

   task automatic send_frame(input logic [31:0] w);
      for (int k = 0; k < 4; k++) good_byte(w[31-8*k -: 8], 6);
   endtask

   task automatic pulse_arm();
      bus.arm = 1'b1; @(negedge clk); bus.arm = 1'b0;
      m_idx = 0; m_flag = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         @(negedge clk); n++;
      end
      idle(4);
      chk({name, "_drain"}, exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic check_cnt(input string name);
      chk({name, "_ok_cnt"},    bus.ok_cnt,    m_ok);
      chk({name, "_fault_cnt"}, bus.fault_cnt, m_fault);
      chk({name, "_err_cnt"},   bus.err_cnt,   m_err);
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      ev_t e;
      if (bus.frame_err) begin
         if (exp_q.size() == 0) spurious("frame_err");
         else begin e = exp_q.pop_front(); chk("frame_err_kind", e.kind, EV_ERR); end
      end
      if (bus.byte_valid) begin
         if (exp_q.size() == 0) spurious("byte_valid");
         else begin
            e = exp_q.pop_front();
            chk("byte_kind", e.kind, EV_BYTE);
            chk("byte_data", bus.byte_data, e.data);
         end
      end
      if (bus.frame_done) begin
         if (exp_q.size() == 0) spurious("frame_done");
         else begin
            e = exp_q.pop_front();
            chk("done_kind", e.kind, EV_DONE);
            chk("frame_match", bus.frame_match, e.match);
            chk("frame_fault", bus.frame_fault, !e.match);
         end
      end else if (bus.frame_match || bus.frame_fault) begin
         spurious("match_fault_without_done");
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      int mode, pos, gap;
      logic [7:0] b;
      bus.rx = 1'b1; bus.arm = 1'b0; bus.clr_cnt = 1'b0;
      idle(3);
      chk("rst_byte_valid", bus.byte_valid, 0);
      chk("rst_byte_data",  bus.byte_data,  0);
      chk("rst_frame_done", bus.frame_done, 0);
      chk("rst_frame_err",  bus.frame_err,  0);
      check_cnt("rst");
      rst_n = 1'b1;
      idle(5);

      send_frame(32'hDEADBEEF);
      drain("t1"); check_cnt("t1");

      send_frame(32'hDEADBEEE);
      drain("t2"); check_cnt("t2");

      good_byte(8'hDE, 6);
      model_err();
      send_byte(8'hAD, 1'b0);
      idle(8);
      send_frame(32'hDEADBEEF);
      drain("t3"); check_cnt("t3");

      good_byte(8'hDE, 6);
      good_byte(8'hAD, 0);
      model_err();
      idle(250);
      send_frame(32'hDEADBEEF);
      drain("t4"); check_cnt("t4");

      bus.rx = 1'b0; idle(3); bus.rx = 1'b1; idle(20);
      good_byte(8'hDE, 6);
      good_byte(8'hAD, 6);
      pulse_arm();
      idle(4);
      send_frame(32'hDEADBEEF);
      drain("t5"); check_cnt("t5");

      force dut.fault_cnt = 16'hFFFE;
      @(negedge clk);
      release dut.fault_cnt;
      m_fault = 65534;
      idle(2);
      chk("t6_preset", bus.fault_cnt, 16'hFFFE);
      send_frame(32'h00ADBEEF);
      send_frame(32'hDEADBE00);
      drain("t6"); check_cnt("t6_sat");
      bus.clr_cnt = 1'b1; @(negedge clk); bus.clr_cnt = 1'b0;
      m_ok = 0; m_fault = 0; m_err = 0;
      idle(2);
      check_cnt("t6_clr");

      // ARM landing exactly on the BYTE_VALID cycle discards that byte
      good_byte(8'hDE, 6);
      model_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      for (int n = 0; n < 20 && !bus.byte_valid; n++) @(negedge clk);
      chk("t7_byte_valid_seen", bus.byte_valid, 1);
      bus.arm = 1'b1; @(negedge clk); bus.arm = 1'b0;
      idle(6);
      send_frame(32'hDEADBEEF);
      drain("t7"); check_cnt("t7");

      // Reset in the middle of a frame and a byte
      good_byte(8'hDE, 4);
      drain("t8_pre");
      bus.rx = 1'b0; idle(30);
      rst_n = 1'b0; idle(2);
      m_ok = 0; m_fault = 0; m_err = 0; m_idx = 0; m_flag = 1'b0;
      chk("t8_rst_byte_data", bus.byte_data, 0);
      check_cnt("t8_rst");
      bus.rx = 1'b1; idle(2);
      rst_n = 1'b1; idle(20);
      send_frame(32'hDEADBEEF);
      drain("t8"); check_cnt("t8");

      // Randomized attempts: corrupted bytes, framing errors, ARMs and line glitches
      for (int f = 0; f < 10; f++) begin
         mode = $urandom_range(0, 5);
         pos  = $urandom_range(0, 3);
         for (int k = 0; k < 4; k++) begin
            b   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : exp_bytes[k];
            gap = $urandom_range(4, 60);
            if (mode == 0 && k == pos) begin
               model_err();
               send_byte(b, 1'b0);
               idle(12);
            end else begin
               good_byte(b, gap);
            end
            if (mode == 1 && k == pos) begin
               pulse_arm();
               idle(4);
            end
            if ($urandom_range(0, 3) == 0) begin
               bus.rx = 1'b0; idle($urandom_range(1, 3)); bus.rx = 1'b1; idle(12);
            end
         end
      end
      pulse_arm();
      drain("rand"); check_cnt("rand");

      chk("final_queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
